// File: rtl/frame_cfg_pkg.sv
// Shared types and constants for the frame write path: FSM states, frame
// address register field positions and the committed-frame counter width.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STROBE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam int unsigned ROW_SEL_W = 5;
    localparam logic [ROW_SEL_W-1:0] ADDR_ROW = '1;

    localparam int unsigned FAR_COL_LSB   = 27;
    localparam int unsigned FAR_COL_W     = 5;
    localparam int unsigned FAR_FRAME_LSB = 0;
    localparam int unsigned FAR_FRAME_W   = 5;

    localparam int unsigned FRAMES_CNT_W = 16;

endpackage

// File: rtl/frame_select_decoder.sv
// Combinational column/frame to one-hot FrameSelect decode; the parent
// registers the result.
module frame_select_decoder
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NumberOfCols    = 19,
    parameter int unsigned MaxFramesPerCol = 20
) (
    input  logic                                    en,
    input  logic [FAR_COL_W-1:0]                    col,
    input  logic [FAR_FRAME_W-1:0]                  frame,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] sel_c
);

    for (genvar c = 0; c < NumberOfCols; c++) begin : g_col
        for (genvar f = 0; f < MaxFramesPerCol; f++) begin : g_frame
            assign sel_c[c*MaxFramesPerCol + f] = en &&
                                                  (col == FAR_COL_W'(c)) &&
                                                  (frame == FAR_FRAME_W'(f));
        end
    end

endmodule

// File: rtl/frame_write_controller.sv
// Collects one word per fabric row, then pulses the addressed FrameSelect
// bit while FrameData is held; tracks protocol errors and committed frames.
module frame_write_controller
    import frame_cfg_pkg::*;
#(
    parameter int unsigned NumberOfRows    = 16,
    parameter int unsigned NumberOfCols    = 19,
    parameter int unsigned FrameBitsPerRow = 32,
    parameter int unsigned MaxFramesPerCol = 20,
    parameter int unsigned RowSelectWidth  = ROW_SEL_W,
    parameter int unsigned StrobeCycles    = 2
) (
    input  logic                                    CLK,
    input  logic                                    reset,
    input  logic [FrameBitsPerRow-1:0]              FrameAddressRegister,
    input  logic                                    LongFrameStrobe,
    input  logic [RowSelectWidth-1:0]               RowSelect,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [NumberOfCols*MaxFramesPerCol-1:0] FrameSelect,
    output logic                                    Busy,
    output logic                                    ErrFlag,
    output logic [FRAMES_CNT_W-1:0]                 FramesWritten
);

    localparam int unsigned SelW = NumberOfCols * MaxFramesPerCol;
    localparam int unsigned CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
    localparam logic [CntW-1:0] StrobeLast = CntW'(StrobeCycles - 1);

    state_t                   state_q, state_d;
    logic [NumberOfRows-1:0]  row_valid_q;
    logic [NumberOfRows-1:0]  row_set;
    logic [FAR_COL_W-1:0]     col_q;
    logic [FAR_FRAME_W-1:0]   frame_q;
    logic [FAR_COL_W-1:0]     far_col;
    logic [FAR_FRAME_W-1:0]   far_frame;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [SelW-1:0]          sel_c;
    logic                     is_addr, is_data, addr_ok;
    logic                     row_we, addr_we, rv_clear, err_set, count_inc;

    assign far_col   = FrameAddressRegister[FAR_COL_LSB +: FAR_COL_W];
    assign far_frame = FrameAddressRegister[FAR_FRAME_LSB +: FAR_FRAME_W];
    assign is_addr   = LongFrameStrobe && (&RowSelect);
    assign is_data   = LongFrameStrobe && (32'(RowSelect) < NumberOfRows);
    assign addr_ok   = (32'(far_col) < NumberOfCols) && (32'(far_frame) < MaxFramesPerCol);
    assign row_set   = row_we ? (NumberOfRows'(1) << RowSelect) : '0;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and datapath controls; words arriving once the frame is
    // complete (commit cycle, STROBE, HOLD) are dropped as protocol errors.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_we    = 1'b0;
        addr_we   = 1'b0;
        rv_clear  = 1'b0;
        err_set   = 1'b0;
        count_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_addr && addr_ok) begin
                    addr_we  = 1'b1;
                    rv_clear = 1'b1;
                    state_d  = COLLECT;
                end else if (LongFrameStrobe) begin
                    err_set = 1'b1;
                end
            end
            COLLECT: begin
                cnt_d = '0;
                if (&row_valid_q) begin
                    state_d = STROBE;
                    err_set = LongFrameStrobe;
                end else if (is_data) begin
                    row_we = 1'b1;
                end else if (is_addr && addr_ok) begin
                    addr_we  = 1'b1;
                    rv_clear = 1'b1;
                    err_set  = |row_valid_q;
                end else if (LongFrameStrobe) begin
                    err_set = 1'b1;
                end
            end
            STROBE: begin
                err_set = LongFrameStrobe;
                if (cnt_q == StrobeLast) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            HOLD: begin
                err_set   = LongFrameStrobe;
                count_inc = 1'b1;
                rv_clear  = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    frame_select_decoder #(
        .NumberOfCols    (NumberOfCols),
        .MaxFramesPerCol (MaxFramesPerCol)
    ) u_decoder (
        .en    (state_d == STROBE),
        .col   (col_q),
        .frame (frame_q),
        .sel_c (sel_c)
    );

    // Registered datapath and outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            FrameData     <= '0;
            FrameSelect   <= '0;
            Busy          <= 1'b0;
            ErrFlag       <= 1'b0;
            FramesWritten <= '0;
            row_valid_q   <= '0;
            col_q         <= '0;
            frame_q       <= '0;
        end else begin
            for (int unsigned r = 0; r < NumberOfRows; r++) begin
                if (row_we && (32'(RowSelect) == r)) begin
                    FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= FrameAddressRegister;
                end
            end
            if (addr_we) begin
                col_q   <= far_col;
                frame_q <= far_frame;
            end
            row_valid_q   <= rv_clear ? '0 : (row_valid_q | row_set);
            FrameSelect   <= sel_c;
            Busy          <= (state_d == STROBE) || (state_d == HOLD);
            ErrFlag       <= ErrFlag | err_set;
            FramesWritten <= FramesWritten + FRAMES_CNT_W'(count_inc);
        end
    end

endmodule
